// File: rtl/snake_uart_tx_if.sv
// Byte-write handshake and status flags between game logic and the snake UART transmitter.
// Game logic drives the master side and the transmitter implements the slave side.
interface snake_uart_tx_if;
    logic [7:0] dataTX;
    logic       WR_TX;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;

    modport master (
        output dataTX,
        output WR_TX,
        input  full,
        input  empty,
        input  busy,
        input  overflow
    );

    modport slave (
        input  dataTX,
        input  WR_TX,
        output full,
        output empty,
        output busy,
        output overflow
    );
endinterface

// File: rtl/snake_uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO for the snake game's link to the host.
// The serial line and all status flags come straight from flops.
module snake_uart_tx #(
    parameter int BAUD_DIV   = 217,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    snake_uart_tx_if.slave bus,
    output logic          tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             busy_r;
    logic             overflow_r;
    logic             tx_r;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt_s;
    logic [15:0]      baud_r;
    logic [15:0]      baud_nxt_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_nxt_s;

    logic             push_s;
    logic             drop_s;
    logic             pop_s;
    logic             bit_end_s;
    logic             line_s;

    // Write acceptance uses the registered full flag, so a pop on the same edge cannot rescue a write.
    always_comb begin
        push_s    = bus.WR_TX & ~full_r;
        drop_s    = bus.WR_TX & full_r;
        bit_end_s = (baud_r == BAUD_LAST);
    end

    // Frame sequencer: next state, shift register, baud and bit counters, pop request and line level.
    always_comb begin
        state_nxt_s = state_r;
        shift_nxt_s = shift_r;
        baud_nxt_s  = baud_r;
        idx_nxt_s   = idx_r;
        pop_s       = 1'b0;
        line_s      = 1'b1;
        case (state_r)
            ST_IDLE: begin
                line_s = 1'b1;
                if (!empty_r) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = mem_r[rd_ptr_r];
                    baud_nxt_s  = 16'd0;
                    idx_nxt_s   = 3'd0;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                line_s = 1'b0;
                if (bit_end_s) begin
                    baud_nxt_s  = 16'd0;
                    state_nxt_s = ST_DATA;
                end else begin
                    baud_nxt_s  = baud_r + 16'd1;
                end
            end
            ST_DATA: begin
                line_s = shift_r[0];
                if (bit_end_s) begin
                    baud_nxt_s  = 16'd0;
                    shift_nxt_s = {1'b0, shift_r[7:1]};
                    if (idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        idx_nxt_s   = idx_r + 3'd1;
                    end
                end else begin
                    baud_nxt_s  = baud_r + 16'd1;
                end
            end
            ST_STOP: begin
                line_s = 1'b1;
                if (bit_end_s) begin
                    baud_nxt_s = 16'd0;
                    // Chain straight into the next start bit when a byte is already waiting.
                    if (!empty_r) begin
                        pop_s       = 1'b1;
                        shift_nxt_s = mem_r[rd_ptr_r];
                        idx_nxt_s   = 3'd0;
                        state_nxt_s = ST_START;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    baud_nxt_s = baud_r + 16'd1;
                end
            end
            default: begin
                line_s      = 1'b1;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FIFO occupancy after this edge's push and pop.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // FIFO storage; contents are only ever changed by accepted writes.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.dataTX;
        end
    end

    // FIFO pointers, count and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            cnt_r      <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            cnt_r      <= cnt_nxt_s;
            full_r     <= (cnt_nxt_s == CNT_FULL);
            empty_r    <= (cnt_nxt_s == '0);
            busy_r     <= (state_r != ST_IDLE) || !empty_r;
            overflow_r <= drop_s;
        end
    end

    // Sequencer state and the line flop; reset drives the line idle-high without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            shift_r <= 8'h00;
            baud_r  <= 16'd0;
            idx_r   <= 3'd0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            shift_r <= shift_nxt_s;
            baud_r  <= baud_nxt_s;
            idx_r   <= idx_nxt_s;
            tx_r    <= line_s;
        end
    end

    assign tx           = tx_r;
    assign bus.full     = full_r;
    assign bus.empty    = empty_r;
    assign bus.busy     = busy_r;
    assign bus.overflow = overflow_r;

endmodule
